vga_vram_arbiter: RTL and testbench

Shares one single-port 32-bit video RAM between the 640x480 display scan-out and a host write port. It sits between the VGA timing generator, the VRAM and the pixel DAC outputs. A prefetch FIFO keeps the display fed, so display reads have absolute priority and never underrun at 25 MHz. The host gets every memory cycle the display does not need.

---
 rtl/vga_vram_pkg.sv | 24 ++
 rtl/vga_pix_fifo.sv | 57 +++++
 rtl/vga_vram_arbiter.sv | 146 ++++++++++++++
 tb/tb_vga_vram_arbiter.sv | 396 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_vram_pkg.sv
// Shared constants and types for the VGA/VRAM arbiter slice.
// Optional byte masking is enabled with VRAM_BYTE_MASK_EN.
package vga_vram_pkg;

  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;
  localparam int PIX_PER_WORD = 4;
  localparam int WORDS_PER_FRAME =
    H_ACTIVE * V_ACTIVE / PIX_PER_WORD;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DONE
  } state_t;

  localparam int R_MSB = 7;
  localparam int R_LSB = 5;
  localparam int G_MSB = 4;
  localparam int G_LSB = 2;
  localparam int B_MSB = 1;
  localparam int B_LSB = 0;

endpackage

// File: rtl/vga_pix_fifo.sv
// Prefetch FIFO holding VRAM words ahead of pixel scan-out.
// Flush has priority over push and pop.
module vga_pix_fifo #(
  parameter int DEPTH = 4,
  parameter int W = 32
) (
  input  logic                     clk,
  input  logic                     clr,
  input  logic                     flush,
  input  logic                     push,
  input  logic [W-1:0]             din,
  input  logic                     pop,
  output logic [W-1:0]             dout,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic          full;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;
  assign dout    = mem[rp];

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else if (flush) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop)  rp <= rp + 1'b1;
      unique case (1'b1)
        do_push && !do_pop: count <= count + 1'b1;
        do_pop && !do_push: count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wp] <= din;
  end

endmodule

// File: rtl/vga_vram_arbiter.sv
// Single-port VRAM arbiter: display prefetch first, host writes otherwise.
// Define VRAM_BYTE_MASK_EN to add per-byte host write enables.
module vga_vram_arbiter #(
  parameter int WORDS_PER_FRAME = vga_vram_pkg::WORDS_PER_FRAME,
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W = 17
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              frame_start,
  input  logic              vidon,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [31:0]       wr_data,
`ifdef VRAM_BYTE_MASK_EN
  input  logic [3:0]        wr_be,
  output logic [3:0]        mem_be,
`endif
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic [2:0]        red,
  output logic [2:0]        green,
  output logic [1:0]        blue,
  output logic              underrun
);

  import vga_vram_pkg::*;

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [ADDR_W-1:0] LAST =
    ADDR_W'(WORDS_PER_FRAME - 1);

  state_t            state;
  state_t            nstate;
  logic [ADDR_W-1:0] rd_ptr;
  logic              rd_pend;
  logic              rd_drop;
  logic              rd_slot;
  logic              room;
  logic [1:0]        sub;
  logic [7:0]        pix;
  logic [31:0]       f_dout;
  logic              f_empty;
  logic [CW-1:0]     f_count;
  logic              f_push;
  logic              f_pop;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) state <= IDLE;
    else      state <= nstate;
  end

  always_comb begin
    nstate = state;
    unique case (1'b1)
      frame_start: nstate = FETCH;
      !frame_start && state == FETCH &&
        rd_slot && rd_ptr == LAST: nstate = DONE;
      default: ;
    endcase
  end

  // In-flight read counts against FIFO space so prefetch never overfills.
  always_comb begin
    room      = (int'(f_count) + int'(rd_pend)) < FIFO_DEPTH;
    rd_slot   = clr && state == FETCH && room;
    wr_ready  = clr && !rd_slot;
    mem_en    = rd_slot || (wr_ready && wr_valid);
    mem_we    = wr_ready && wr_valid;
    mem_addr  = rd_slot ? rd_ptr : wr_addr;
    mem_wdata = wr_data;
`ifdef VRAM_BYTE_MASK_EN
    mem_be    = rd_slot ? 4'b0000 : wr_be;
`endif
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      rd_ptr  <= '0;
      rd_pend <= 1'b0;
      rd_drop <= 1'b0;
    end else begin
      rd_pend <= rd_slot;
      if (frame_start) begin
        rd_ptr  <= '0;
        rd_drop <= rd_slot;
      end else begin
        rd_drop <= 1'b0;
        if (rd_slot) rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  assign f_push = rd_pend && !rd_drop;
  assign f_pop  = vidon && !f_empty &&
                  !frame_start && sub == 2'd3;

  vga_pix_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (32)
  ) u_fifo (
    .clk   (clk),
    .clr   (clr),
    .flush (frame_start),
    .push  (f_push),
    .din   (mem_rdata),
    .pop   (f_pop),
    .dout  (f_dout),
    .empty (f_empty),
    .count (f_count)
  );

  assign pix = f_dout[{sub, 3'b000} +: 8];

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      red      <= '0;
      green    <= '0;
      blue     <= '0;
      underrun <= 1'b0;
      sub      <= '0;
    end else begin
      red   <= '0;
      green <= '0;
      blue  <= '0;
      if (frame_start) begin
        sub      <= '0;
        underrun <= 1'b0;
      end else if (vidon) begin
        if (f_empty) begin
          underrun <= 1'b1;
        end else begin
          red   <= pix[R_MSB:R_LSB];
          green <= pix[G_MSB:G_LSB];
          blue  <= pix[B_MSB:B_LSB];
          sub   <= sub + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_vga_vram_arbiter.sv
// Directed bench for vga_vram_arbiter with a behavioural VRAM.
// Uses a shortened frame so a full frame fits in a short run.
module tb_vga_vram_arbiter;

  localparam int WPF = 1200;
  localparam int AW = 17;

  logic          clk = 1'b0;
  logic          clr = 1'b0;
  logic          frame_start = 1'b0;
  logic          vidon = 1'b0;
  logic          wr_valid = 1'b0;
  logic          wr_ready;
  logic [AW-1:0] wr_addr = '0;
  logic [31:0]   wr_data = '0;
`ifdef VRAM_BYTE_MASK_EN
  logic [3:0]    wr_be = 4'hF;
  logic [3:0]    mem_be;
`endif
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata = '0;
  logic [2:0]    red;
  logic [2:0]    green;
  logic [1:0]    blue;
  logic          underrun;

  int checks = 0;
  int errors = 0;
  int rd_cnt = 0;
  logic [AW-1:0] rd_last = '0;
  logic [31:0] vram [0:2047];
  logic [7:0] first4 [4];

  always #20 clk = ~clk;

  vga_vram_arbiter #(
    .WORDS_PER_FRAME (WPF),
    .FIFO_DEPTH      (4),
    .ADDR_W          (AW)
  ) dut (
    .clk         (clk),
    .clr         (clr),
    .frame_start (frame_start),
    .vidon       (vidon),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
`ifdef VRAM_BYTE_MASK_EN
    .wr_be       (wr_be),
    .mem_be      (mem_be),
`endif
    .mem_en      (mem_en),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .red         (red),
    .green       (green),
    .blue        (blue),
    .underrun    (underrun)
  );

  always @(posedge clk) begin
    if (mem_en && mem_we) begin
`ifdef VRAM_BYTE_MASK_EN
      for (int b = 0; b < 4; b++)
        if (mem_be[b])
          vram[mem_addr[10:0]][8*b +: 8] <= mem_wdata[8*b +: 8];
`else
      vram[mem_addr[10:0]] <= mem_wdata;
`endif
    end
    if (mem_en && !mem_we)
      mem_rdata <= vram[mem_addr[10:0]];
  end

  always @(posedge clk) begin
    if (frame_start) begin
      rd_cnt <= 0;
    end else if (mem_en && !mem_we) begin
      rd_cnt  <= rd_cnt + 1;
      rd_last <= mem_addr;
    end
  end

  function automatic logic [31:0] pat(input int i);
    logic [31:0] v;
    if (i == 0) return 32'hFF1C_E003;
    v = {8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)};
    return v ^ 32'h5A5A_5A5A;
  endfunction

  function automatic logic [7:0] exp_pix(input int idx);
    logic [31:0] w;
    w = pat(idx / 4);
    return 8'(w >> (8 * (idx % 4)));
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    clr = 1'b0;
    wr_valid = 1'b1;
    wr_addr = AW'(1800);
    wr_data = 32'h1234_5678;
    tick();
    tick();
    @(negedge clk);
    checks++;
    if (wr_ready !== 1'b0) begin
      errors++;
      $display("FAIL rst_wr_ready got %b want 0", wr_ready);
    end
    checks++;
    if (mem_en !== 1'b0) begin
      errors++;
      $display("FAIL rst_mem_en got %b want 0", mem_en);
    end
    checks++;
    if ({red, green, blue} !== 8'h00) begin
      errors++;
      $display("FAIL rst_rgb got %h want 00", {red, green, blue});
    end
    checks++;
    if (underrun !== 1'b0) begin
      errors++;
      $display("FAIL rst_underrun got %b want 0", underrun);
    end
    tick();
    clr = 1'b1;
    @(negedge clk);
    checks++;
    if (wr_ready !== 1'b1 || mem_en !== 1'b1 || mem_we !== 1'b1) begin
      errors++;
      $display("FAIL idle_host got rdy%b en%b we%b want 1 1 1",
               wr_ready, mem_en, mem_we);
    end
    tick();
    wr_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (vram[1800] !== 32'h1234_5678) begin
      errors++;
      $display("FAIL idle_write got %h want 12345678", vram[1800]);
    end
  endtask

  task automatic test_underrun();
    tick();
    vidon = 1'b1;
    tick();
    vidon = 1'b0;
    @(negedge clk);
    checks++;
    if ({red, green, blue} !== 8'h00 || underrun !== 1'b1) begin
      errors++;
      $display("FAIL underrun got rgb %h flag %b want 00 1",
               {red, green, blue}, underrun);
    end
  endtask

  task automatic test_prefill();
    tick();
    frame_start = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      tick();
      frame_start = 1'b0;
      @(negedge clk);
      checks++;
      if (mem_en !== 1'b1 || mem_we !== 1'b0 ||
          mem_addr !== AW'(c - 1) || wr_ready !== 1'b0) begin
        errors++;
        $display("FAIL prefill_%0d got en%b we%b a%0d rdy%b want 1 0 %0d 0",
                 c, mem_en, mem_we, mem_addr, wr_ready, c - 1);
      end
      if (c == 1) begin
        checks++;
        if (underrun !== 1'b0) begin
          errors++;
          $display("FAIL underrun_clear got %b want 0", underrun);
        end
      end
    end
    for (int c = 5; c <= 8; c++) begin
      tick();
      @(negedge clk);
      checks++;
      if (wr_ready !== 1'b1 || mem_en !== 1'b0) begin
        errors++;
        $display("FAIL full_%0d got rdy%b en%b want 1 0",
                 c, wr_ready, mem_en);
      end
    end
  endtask

  task automatic check_first4(input string tag);
    tick();
    vidon = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (k == 3) vidon = 1'b0;
      @(negedge clk);
      checks++;
      if ({red, green, blue} !== first4[k]) begin
        errors++;
        $display("FAIL %s_pix%0d got %h want %h",
                 tag, k, {red, green, blue}, first4[k]);
      end
    end
  endtask

  task automatic test_pixel_order();
    check_first4("order");
    checks++;
    if (mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== AW'(4)) begin
      errors++;
      $display("FAIL refill got en%b we%b a%0d want 1 0 4",
               mem_en, mem_we, mem_addr);
    end
  endtask

  task automatic test_interleave();
    int acc;
    logic [7:0] e;
    acc = 0;
    for (int i = 0; i < 640; i++) begin
      tick();
      vidon = 1'b1;
      wr_valid = 1'b1;
      wr_addr = AW'(1300 + (i & 511));
      wr_data = 32'(i);
      @(negedge clk);
      if (wr_ready) acc++;
      if (i > 0) begin
        e = exp_pix(4 + i - 1);
        checks++;
        if ({red, green, blue} !== e) begin
          errors++;
          $display("FAIL line_pix%0d got %h want %h",
                   i - 1, {red, green, blue}, e);
        end
      end
    end
    tick();
    vidon = 1'b0;
    wr_valid = 1'b0;
    @(negedge clk);
    e = exp_pix(643);
    checks++;
    if ({red, green, blue} !== e) begin
      errors++;
      $display("FAIL line_last got %h want %h", {red, green, blue}, e);
    end
    checks++;
    if (acc < 480) begin
      errors++;
      $display("FAIL host_share got %0d want >=480", acc);
    end
    checks++;
    if (underrun !== 1'b0) begin
      errors++;
      $display("FAIL line_underrun got %b want 0", underrun);
    end
    vram[1900] = 32'h1122_3344;
    repeat (4) tick();
    wr_valid = 1'b1;
    wr_addr = AW'(1900);
    wr_data = 32'hDDCC_AABB;
`ifdef VRAM_BYTE_MASK_EN
    wr_be = 4'b0010;
`endif
    tick();
    wr_valid = 1'b0;
`ifdef VRAM_BYTE_MASK_EN
    wr_be = 4'hF;
`endif
    @(negedge clk);
    checks++;
`ifdef VRAM_BYTE_MASK_EN
    if (vram[1900] !== 32'h1122_AA44) begin
      errors++;
      $display("FAIL byte_mask got %h want 1122aa44", vram[1900]);
    end
`else
    if (vram[1900] !== 32'hDDCC_AABB) begin
      errors++;
      $display("FAIL full_write got %h want ddccaabb", vram[1900]);
    end
`endif
  endtask

  task automatic test_frame_end();
    int n;
    logic ok;
    n = 0;
    while (rd_cnt < WPF && n < 6000) begin
      tick();
      vidon = 1'b1;
      n++;
    end
    checks++;
    if (rd_cnt != WPF) begin
      errors++;
      $display("FAIL frame_reads got %0d want %0d", rd_cnt, WPF);
    end
    checks++;
    if (rd_last !== AW'(WPF - 1)) begin
      errors++;
      $display("FAIL last_addr got %0d want %0d", rd_last, WPF - 1);
    end
    ok = 1'b1;
    for (int j = 0; j < 20; j++) begin
      tick();
      @(negedge clk);
      if (wr_ready !== 1'b1) ok = 1'b0;
    end
    checks++;
    if (!ok || rd_cnt != WPF) begin
      errors++;
      $display("FAIL done_state got ok%b reads %0d want 1 %0d",
               ok, rd_cnt, WPF);
    end
    tick();
    vidon = 1'b0;
  endtask

  task automatic test_restart();
    int n;
    logic found;
    tick();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    repeat (6) tick();
    n = 0;
    found = 1'b0;
    while (!found && n < 6000) begin
      tick();
      vidon = 1'b1;
      #1;
      if (mem_en && !mem_we && mem_addr == AW'(1000)) begin
        frame_start = 1'b1;
        found = 1'b1;
      end
      n++;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL reach_1000 got none want read at 1000");
    end
    tick();
    frame_start = 1'b0;
    vidon = 1'b0;
    @(negedge clk);
    checks++;
    if (mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== '0) begin
      errors++;
      $display("FAIL restart_addr got en%b we%b a%0d want 1 0 0",
               mem_en, mem_we, mem_addr);
    end
    checks++;
    if ({red, green, blue} !== 8'h00 || underrun !== 1'b0) begin
      errors++;
      $display("FAIL restart_out got rgb %h flag %b want 00 0",
               {red, green, blue}, underrun);
    end
    repeat (5) tick();
    check_first4("restart");
  endtask

  initial begin
    first4[0] = 8'h03;
    first4[1] = 8'hE0;
    first4[2] = 8'h1C;
    first4[3] = 8'hFF;
    for (int i = 0; i < 2048; i++) vram[i] = pat(i);
    test_reset();
    test_underrun();
    test_prefill();
    test_pixel_order();
    test_interleave();
    test_frame_end();
    test_restart();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
